// File: rtl/tap_serializer_if.sv
// Byte stream link from tap_serializer to its consumer: valid/ready handshake
// with an end-of-frame marker.
interface tap_serializer_if #(
    parameter int DW = 8
);
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/tap_serializer.sv
// Snapshots three pipeline tap bytes on a sample strobe and streams them as a
// framed byte sequence. TAP_SERIALIZER_CHECKSUM_EN appends an XOR checksum byte.
module tap_serializer #(
    parameter int             DW  = 8,
    parameter logic [DW-1:0]  SOF = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DW-1:0]     i_tap1,
    input  logic [DW-1:0]     i_tap2,
    input  logic [DW-1:0]     i_tap3,
    input  logic              i_sample,
    tap_serializer_if.master  m_if,
    output logic              o_busy,
    output logic [7:0]        o_drop_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_B1   = 3'd2;
    localparam logic [2:0] S_B2   = 3'd3;
    localparam logic [2:0] S_B3   = 3'd4;
`ifdef TAP_SERIALIZER_CHECKSUM_EN
    localparam logic [2:0] S_CK   = 3'd5;
    localparam logic [2:0] S_LAST = S_CK;
`else
    localparam logic [2:0] S_LAST = S_B3;
`endif

    logic [2:0]    r_state;
    logic [DW-1:0] r_h1, r_h2, r_h3;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_last;
    logic [7:0]    r_drop_cnt;

    logic          w_hs;
    logic          w_capture;
    logic          w_drop;
    logic [2:0]    w_state_nxt;
    logic [DW-1:0] w_h1, w_h2, w_h3;
    logic [DW-1:0] w_data_nxt;

    always_comb begin
        w_hs        = r_valid & m_if.m_ready;
        w_capture   = 1'b0;
        w_state_nxt = r_state;
        if (r_state == S_IDLE) begin
            if (i_sample) begin
                w_capture   = 1'b1;
                w_state_nxt = S_HDR;
            end
        end else if (w_hs) begin
            if (r_state == S_LAST) begin
                w_capture   = i_sample;
                w_state_nxt = i_sample ? S_HDR : S_IDLE;
            end else begin
                w_state_nxt = r_state + 3'd1;
            end
        end
        // In IDLE a sample always captures, so anything not captured is a drop.
        w_drop = i_sample & ~w_capture;

        w_h1 = w_capture ? i_tap1 : r_h1;
        w_h2 = w_capture ? i_tap2 : r_h2;
        w_h3 = w_capture ? i_tap3 : r_h3;

        // Output byte is precomputed from the next state so outputs stay registered.
        w_data_nxt = '0;
        case (w_state_nxt)
            S_HDR:   w_data_nxt = SOF;
            S_B1:    w_data_nxt = w_h1;
            S_B2:    w_data_nxt = w_h2;
            S_B3:    w_data_nxt = w_h3;
`ifdef TAP_SERIALIZER_CHECKSUM_EN
            S_CK:    w_data_nxt = SOF ^ w_h1 ^ w_h2 ^ w_h3;
`endif
            default: w_data_nxt = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_h1       <= '0;
            r_h2       <= '0;
            r_h3       <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_h1    <= w_h1;
            r_h2    <= w_h2;
            r_h3    <= w_h3;
            r_valid <= (w_state_nxt != S_IDLE);
            r_data  <= w_data_nxt;
            r_last  <= (w_state_nxt == S_LAST);
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign m_if.m_valid = r_valid;
    assign m_if.m_data  = r_data;
    assign m_if.m_last  = r_last;
    assign o_busy       = (r_state != S_IDLE);
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_tap_serializer.sv
// Directed bench for tap_serializer; frame length follows
// TAP_SERIALIZER_CHECKSUM_EN so either build can be checked.
module tb_tap_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample;
    logic [7:0] tap1, tap2, tap3;
    logic       busy;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    tap_serializer_if #(.DW(8)) bus ();

    tap_serializer #(.DW(8), .SOF(8'hA5)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_tap1     (tap1),
        .i_tap2     (tap2),
        .i_tap3     (tap3),
        .i_sample   (sample),
        .m_if       (bus),
        .o_busy     (busy),
        .o_drop_cnt (drop_cnt)
    );

`ifdef TAP_SERIALIZER_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    int n_tests  = 0;
    int n_fail   = 0;
    int exp_drop = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_drop();
        exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    endtask

    task automatic start(input logic [7:0] t1, input logic [7:0] t2, input logic [7:0] t3);
        tap1 = t1; tap2 = t2; tap3 = t3;
        sample = 1'b1;
        tick();
        sample = 1'b0;
    endtask

    // Expects SOF already on the bus; walks the whole frame.
    task automatic run_frame(input logic [7:0] t1, input logic [7:0] t2, input logic [7:0] t3,
                             input int stall_at, input int stall_n, input int drops,
                             input logic b2b,
                             input logic [7:0] n1, input logic [7:0] n2, input logic [7:0] n3);
        logic [7:0] fr [5];
        fr[0] = 8'hA5; fr[1] = t1; fr[2] = t2; fr[3] = t3;
        fr[4] = 8'hA5 ^ t1 ^ t2 ^ t3;
        for (int i = 0; i < NB; i++) begin
            if (i == stall_at) begin
                bus.m_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check("stall_valid", bus.m_valid, 1);
                    check("stall_data", bus.m_data, fr[i]);
                    check("stall_last", bus.m_last, (i == NB - 1));
                    tick();
                end
            end
            bus.m_ready = 1'b1;
            check("valid", bus.m_valid, 1);
            check("data", bus.m_data, fr[i]);
            check("last", bus.m_last, (i == NB - 1));
            check("busy", busy, 1);
            if (i == NB - 1) begin
                if (b2b) begin
                    sample = 1'b1; tap1 = n1; tap2 = n2; tap3 = n3;
                end
            end else if (i < drops) begin
                sample = 1'b1; tap1 = ~t1; tap2 = ~t2; tap3 = ~t3;
                model_drop();
            end
            tick();
            sample = 1'b0;
        end
        if (!b2b) begin
            check("end_busy", busy, 0);
            check("end_valid", bus.m_valid, 0);
        end
        check("drop_cnt", drop_cnt, exp_drop);
    endtask

    initial begin
        rst = 1'b1; sample = 1'b0; tap1 = '0; tap2 = '0; tap3 = '0;
        bus.m_ready = 1'b0;
        tick(); tick();
        check("rst_valid", bus.m_valid, 0);
        check("rst_data", bus.m_data, 0);
        check("rst_last", bus.m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        tick();
        check("idle_valid", bus.m_valid, 0);

        // Basic frame
        start(8'h05, 8'h04, 8'h03);
        run_frame(8'h05, 8'h04, 8'h03, -1, 0, 0, 1'b0, 8'h0, 8'h0, 8'h0);

        // Backpressure: three stalled cycles on B1
        start(8'h05, 8'h04, 8'h03);
        run_frame(8'h05, 8'h04, 8'h03, 1, 3, 0, 1'b0, 8'h0, 8'h0, 8'h0);

        // Three dropped samples with taps scrambled mid-frame
        start(8'h05, 8'h04, 8'h03);
        run_frame(8'h05, 8'h04, 8'h03, -1, 0, 3, 1'b0, 8'h0, 8'h0, 8'h0);
        check("drop3", drop_cnt, 3);

        // Back-to-back capture on the final handshake
        start(8'h05, 8'h04, 8'h03);
        run_frame(8'h05, 8'h04, 8'h03, -1, 0, 0, 1'b1, 8'h09, 8'h08, 8'h07);
        run_frame(8'h09, 8'h08, 8'h07, -1, 0, 0, 1'b0, 8'h0, 8'h0, 8'h0);

        // Reset in the middle of a frame
        start(8'h10, 8'h20, 8'h40);
        bus.m_ready = 1'b1;
        tick(); tick();
        check("mid_b2_data", bus.m_data, 8'h20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_drop = 0;
        check("mrst_valid", bus.m_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_drop", drop_cnt, 0);
        check("mrst_last", bus.m_last, 0);
        check("mrst_data", bus.m_data, 0);
        start(8'h10, 8'h20, 8'h40);
        run_frame(8'h10, 8'h20, 8'h40, -1, 0, 0, 1'b0, 8'h0, 8'h0, 8'h0);

        // Saturation: 300 drops while SOF is stalled
        start(8'h01, 8'h02, 8'h03);
        bus.m_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            sample = 1'b1;
            model_drop();
            tick();
            if (k == 253) check("drop254", drop_cnt, exp_drop);
        end
        sample = 1'b0;
        check("drop_sat", drop_cnt, 255);
        check("sat_valid", bus.m_valid, 1);
        check("sat_data", bus.m_data, 8'hA5);
        run_frame(8'h01, 8'h02, 8'h03, -1, 0, 0, 1'b0, 8'h0, 8'h0, 8'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
